// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Brief    : PS/2 keyboard frame receiver with a show-ahead scan-code FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
    parameter int KB_W    = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 5000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    input  logic            sig_rd_kb,
    output logic [KB_W-1:0] kb_rdata,
    output logic            kb_ready,
    output logic            kb_ovf,
    output logic            kb_ferr
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_NBITS = KB_W + 2;
    localparam int c_BW    = $clog2(c_NBITS + 1);
    localparam int c_TW    = $clog2(TIMEOUT + 1);

    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(c_NBITS - 1);
    localparam logic [c_TW-1:0] c_TMO_MAX  = c_TW'(TIMEOUT);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RECV  = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;

    logic               r_clk_s1, r_clk_s2, r_clk_s3;
    logic               r_dat_s1, r_dat_s2;
    logic [1:0]         r_state;
    logic [c_BW-1:0]    r_bitcnt;
    logic [c_NBITS-1:0] r_sh;
    logic [c_TW-1:0]    r_tmo;

    logic               w_fall;
    logic               w_check;
    logic               w_valid;
    logic               w_push;

    logic [KB_W-1:0]    r_mem [DEPTH];
    logic [c_AW:0]      r_rd, r_wr;
    logic               r_ovf;
    logic               w_empty, w_full, w_pop, w_wr_en;

    // Synchronisers idle high so reset never looks like a PS/2 falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_s3 & ~r_clk_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_bitcnt <= '0;
            r_sh     <= '0;
            r_tmo    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_tmo <= '0;
                    if (w_fall && !r_dat_s2) begin
                        r_state  <= c_RECV;
                        r_bitcnt <= '0;
                    end
                end
                c_RECV: begin
                    if (w_fall) begin
                        r_sh  <= {r_dat_s2, r_sh[c_NBITS-1:1]};
                        r_tmo <= '0;
                        if (r_bitcnt == c_BIT_LAST) begin
                            r_state  <= c_CHECK;
                            r_bitcnt <= '0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end else begin
                        // Saturating count; the frame is abandoned on the TIMEOUT-th idle cycle.
                        if (r_tmo != c_TMO_MAX) begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                        if (r_tmo >= c_TMO_LAST) begin
                            r_state  <= c_IDLE;
                            r_bitcnt <= '0;
                        end
                    end
                end
                c_CHECK: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // After a full frame: sh[KB_W-1:0] = data, sh[KB_W] = parity, sh[KB_W+1] = stop.
    assign w_check = (r_state == c_CHECK);
    assign w_valid = (^r_sh[KB_W:0]) & r_sh[KB_W+1];
    assign w_push  = w_check & w_valid;
    assign kb_ferr = w_check & ~w_valid;

    assign w_empty = (r_rd == r_wr);
    assign w_full  = (r_rd[c_AW-1:0] == r_wr[c_AW-1:0]) && (r_rd[c_AW] != r_wr[c_AW]);
    assign w_pop   = sig_rd_kb & ~w_empty;
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr[c_AW-1:0]] <= r_sh[KB_W-1:0];
                r_wr                  <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign kb_rdata = r_mem[r_rd[c_AW-1:0]];
    assign kb_ready = ~w_empty;
    assign kb_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Brief    : Scoreboard bench for ps2_kbd_rx driven by directed PS/2 frames.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int KB_W    = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic            ps2_clk;
    logic            ps2_data;
    logic            sig_rd_kb;
    logic [KB_W-1:0] kb_rdata;
    logic            kb_ready;
    logic            kb_ovf;
    logic            kb_ferr;

    int              checks   = 0;
    int              errors   = 0;
    int              ferr_cnt = 0;
    int              f0;
    logic [7:0]      exp_q[$];

    ps2_kbd_rx #(.KB_W(KB_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .sig_rd_kb (sig_rd_kb),
        .kb_rdata  (kb_rdata),
        .kb_ready  (kb_ready),
        .kb_ovf    (kb_ovf),
        .kb_ferr   (kb_ferr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && kb_ferr) ferr_cnt++;
        if (!rst && sig_rd_kb && kb_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", kb_rdata);
            end else begin
                check("pop_data", {24'd0, kb_rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic pflip, input logic stop);
        return {stop, (~^d) ^ pflip, d, 1'b0};
    endfunction

    // mode 0: plain, 1: latency check on stop bit, 2: pop during the CHECK cycle
    task automatic send_bits(input logic [10:0] f, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF) tick;
            ps2_clk = 1'b0;
            if (i == 10 && mode != 0) begin
                repeat (3) tick;
                if (mode == 1) check("lat_ready_early", {31'd0, kb_ready}, 32'd0);
                if (mode == 2) sig_rd_kb = 1'b1;
                tick;
                sig_rd_kb = 1'b0;
                if (mode == 1) begin
                    check("lat_ready", {31'd0, kb_ready}, 32'd1);
                    check("lat_rdata", {24'd0, kb_rdata}, 32'h1C);
                end
                repeat (HALF - 4) tick;
            end else begin
                repeat (HALF) tick;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) tick;
    endtask

    task automatic send(input logic [7:0] d);
        send_bits(frame(d, 1'b0, 1'b1), 11, 0);
    endtask

    task automatic pop;
        sig_rd_kb = 1'b1;
        tick;
        sig_rd_kb = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 2 * DEPTH && kb_ready; k++) pop();
        check({name, "_empty"}, {31'd0, kb_ready}, 32'd0);
        check({name, "_consumed"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        sig_rd_kb = 1'b0;
        repeat (3) tick;
        check("rst_ready", {31'd0, kb_ready}, 32'd0);
        check("rst_rdata", {24'd0, kb_rdata}, 32'd0);
        check("rst_ovf",   {31'd0, kb_ovf},   32'd0);
        check("rst_ferr",  {31'd0, kb_ferr},  32'd0);
        rst = 1'b0;
        tick;
        pop();
        check("pop_empty_ready", {31'd0, kb_ready}, 32'd0);

        // Single frame with latency check, then pop.
        exp_q.push_back(8'h1C);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 1);
        pop();
        check("t1_ready_after_pop", {31'd0, kb_ready}, 32'd0);
        check("t1_consumed", exp_q.size(), 32'd0);

        // Two frames, in-order reads.
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        send(8'hF0);
        send(8'h1C);
        check("t2_ready", {31'd0, kb_ready}, 32'd1);
        check("t2_head", {24'd0, kb_rdata}, 32'hF0);
        drain("t2");

        // Parity error and stop error.
        f0 = ferr_cnt;
        send_bits(frame(8'h1C, 1'b1, 1'b1), 11, 0);
        check("t3_parity_ferr", ferr_cnt - f0, 32'd1);
        check("t3_parity_ready", {31'd0, kb_ready}, 32'd0);
        f0 = ferr_cnt;
        send_bits(frame(8'h1C, 1'b0, 1'b0), 11, 0);
        check("t3_stop_ferr", ferr_cnt - f0, 32'd1);
        check("t3_stop_ready", {31'd0, kb_ready}, 32'd0);

        // Overflow: 9 frames into 8 entries.
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send(8'(i));
        end
        check("t4_ovf", {31'd0, kb_ovf}, 32'd1);
        check("t4_head", {24'd0, kb_rdata}, 32'h01);
        drain("t4");
        check("t4_ovf_sticky", {31'd0, kb_ovf}, 32'd1);

        // Full FIFO with a pop landing on the CHECK cycle.
        do_reset();
        check("t5_ovf_cleared", {31'd0, kb_ovf}, 32'd0);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h11 + 8'(i));
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
        send_bits(frame(8'h19, 1'b0, 1'b1), 11, 2);
        check("t5_ovf", {31'd0, kb_ovf}, 32'd0);
        check("t5_head", {24'd0, kb_rdata}, 32'h12);
        drain("t5");

        // Timeout abandons a partial frame.
        do_reset();
        f0 = ferr_cnt;
        exp_q.push_back(8'h5A);
        send_bits(frame(8'hA5, 1'b0, 1'b1), 5, 0);
        repeat (TIMEOUT + 1) tick;
        send(8'h5A);
        check("t6_tmo_ferr", ferr_cnt - f0, 32'd0);
        check("t6_tmo_head", {24'd0, kb_rdata}, 32'h5A);
        drain("t6");

        // Asynchronous reset mid-frame.
        send(8'h33);
        check("t6_pre_rst_ready", {31'd0, kb_ready}, 32'd1);
        send_bits(frame(8'h66, 1'b0, 1'b1), 6, 0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t6_async_ready", {31'd0, kb_ready}, 32'd0);
        check("t6_async_rdata", {24'd0, kb_rdata}, 32'd0);
        check("t6_async_ovf",   {31'd0, kb_ovf},   32'd0);
        check("t6_async_ferr",  {31'd0, kb_ferr},  32'd0);
        tick;
        rst = 1'b0;
        tick;
        exp_q.push_back(8'h44);
        send(8'h44);
        drain("t6_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
